seq_det_ctrl: RTL and testbench
===============================

// Module: seq_det_ctrl
// PURPOSE
//  Frame controller for the serial sequence detector. Accepts parallel words on a
//  valid/ready port and shifts each word MSB-first onto the detector's serial input.
//  Samples the detector's Y_W-bit output on every bit and reports per-frame results:
//  a hit count and an OR-accumulated hit mask, then pulses done.
// PARAMETERS
//  WORD_W  8  bits per frame serialized onto det_x (>=2)
//  Y_W     4  width of detector output det_y
//  CNT_W   4  width of hit_cnt (saturating)
// PORTS
//  clk       in   1       clock, rising edge
//  rst       in   1       asynchronous, active-low reset
//  in_valid  in   1       word available
//  in_ready  out  1       controller can accept; high only in IDLE
//  in_data   in   WORD_W  word to serialize, MSB first
//  det_rst   out  1       active-high reset to detector (registered)
//  det_x     out  1       serial bit to detector (registered)
//  det_y     in   Y_W     detector output, registered inside detector (1-cycle latency)
//  busy      out  1       high in every state except IDLE
//  done      out  1       one-cycle pulse: frame results valid
//  hit_cnt   out  CNT_W   count of sampled cycles with det_y != 0; saturates at all-ones
//  hit_mask  out  Y_W     bitwise OR of all det_y samples in the frame
// BEHAVIOUR
//  Reset (rst=0): state=IDLE, det_rst=1, det_x=0, done=0, hit_cnt=0, hit_mask=0,
//   shreg=0, bitcnt=0. First clock after release: det_rst->0. Reset is effective in any
//   state; a frame in progress is abandoned, no done pulse.
//  FSM: IDLE -> [CLR] -> SHIFT -> DRAIN -> DONE -> IDLE.
//  IDLE: in_ready=1, det_x=0. Accept on in_valid&&in_ready: load shreg=in_data,
//   clear hit_cnt/hit_mask, bitcnt=0. No accept -> stay, results held.
//  SHIFT: exactly WORD_W cycles; cycle k (0..WORD_W-1) has det_x = in_data[WORD_W-1-k].
//   det_y sampled in SHIFT cycles 1..WORD_W-1 (reflects previous bit); cycle 0 not sampled.
//  DRAIN: one cycle; det_x=0; samples det_y for the last bit. Total WORD_W samples/frame.
//  Sample rule: if det_y!=0 and hit_cnt!=all-ones, hit_cnt+=1; hit_mask|=det_y.
//  DONE: done=1 for one cycle; hit_cnt/hit_mask final and held until next accept.
//  Latency (macro off): accept edge E -> first det_x bit in cycle E+1, done in cycle
//   E+WORD_W+2. Next accept earliest in IDLE cycle after DONE (in_ready low while busy).
//  in_valid while busy is ignored; in_data need not be held after accept.
//  Without frame clear, detector history carries across frames (continuous stream).
// CONFIGURATION
//  SEQ_DET_CTRL_FRAME_CLR_EN defined: accept goes to CLR for one cycle with det_rst=1,
//   det_x=0, no sampling; each frame starts from a clean detector; latency +1 cycle
//   (done at E+WORD_W+3).
//  Not defined: CLR state absent; det_rst high only during/immediately after global reset.
// TESTING
//  (defaults, det_y from a bench stub model)
//  1 in_data=8'hA5 accepted -> det_x over 8 SHIFT cycles = 1,0,1,0,0,1,0,1; done at E+10.
//  2 stub drives det_y=4'b0010 on 3 sample cycles, 4'b1000 on 1 -> hit_cnt=4,
//    hit_mask=4'b1010; held after done until next accept.
//  3 CNT_W=2, det_y=4'b0001 on all 8 samples -> hit_cnt=2'b11 (saturated), hit_mask=4'b0001.
//  4 in_valid held high with 8'hFF then 8'h00 -> in_ready low while busy; second word
//    accepted in IDLE cycle after DONE; no word lost or duplicated.
//  5 rst low in SHIFT bit 4 -> all outputs to reset values immediately, no done;
//    det_rst=1 then 0 after release; new frame runs normally.
//  6 SEQ_DET_CTRL_FRAME_CLR_EN defined -> det_rst=1 for exactly 1 cycle after each
//    accept, first det_x bit one cycle later, done at E+11.

Source files
------------

// File: rtl/seq_det_ctrl.sv
// -----------------------------------------------------------------------------
// seq_det_ctrl
// Frame controller for a serial sequence detector. Takes a parallel word on a
// valid/ready port, shifts it MSB-first onto det_x, samples the detector output
// det_y once per bit, and reports a per-frame hit count and OR-ed hit mask
// followed by a one-cycle done pulse.
//
// Optional feature macro: SEQ_DET_CTRL_FRAME_CLR_EN
//   defined     : each accepted word first spends one CLR cycle holding det_rst
//                 high, so every frame starts from a clean detector (+1 cycle).
//   not defined : no CLR state; detector history carries across frames.
//
// Ports
//   clk       in   1       clock, rising edge
//   rst       in   1       asynchronous active-low reset
//   in_valid  in   1       word available
//   in_ready  out  1       controller can accept (IDLE only)
//   in_data   in   WORD_W  word to serialize, MSB first
//   det_rst   out  1       active-high detector reset
//   det_x     out  1       serial bit to detector
//   det_y     in   Y_W     detector output (1-cycle latency behind det_x)
//   busy      out  1       high in every state except IDLE
//   done      out  1       one-cycle pulse, frame results valid
//   hit_cnt   out  CNT_W   saturating count of samples with det_y != 0
//   hit_mask  out  Y_W     OR of all det_y samples in the frame
// -----------------------------------------------------------------------------
module seq_det_ctrl #(
    parameter int unsigned WORD_W = 8,
    parameter int unsigned Y_W    = 4,
    parameter int unsigned CNT_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    output logic              det_rst,
    output logic              det_x,
    input  logic [Y_W-1:0]    det_y,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [Y_W-1:0]    hit_mask
);

    localparam int unsigned BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
`ifdef SEQ_DET_CTRL_FRAME_CLR_EN
        S_CLR   = 3'd1,
`endif
        S_SHIFT = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t             state_q, state_d;

    logic [WORD_W-1:0]  shreg_q, shreg_d;
    logic [BIT_W-1:0]   bitcnt_q, bitcnt_d;
    logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d;
    logic [Y_W-1:0]     hit_mask_q, hit_mask_d;
    logic               det_x_q, det_x_d;
    logic               det_rst_q, det_rst_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic               in_ready_q, in_ready_d;

    logic               accept_c;
    logic               sample_c;

    // Handshake completes only in IDLE while ready is advertised
    assign accept_c = (state_q == S_IDLE) && in_valid && in_ready_q;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
`ifdef SEQ_DET_CTRL_FRAME_CLR_EN
                    state_d = S_CLR;
`else
                    state_d = S_SHIFT;
`endif
                end
            end
`ifdef SEQ_DET_CTRL_FRAME_CLR_EN
            S_CLR:   state_d = S_SHIFT;
`endif
            S_SHIFT: begin
                if (bitcnt_q == LAST_BIT) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output and datapath next values; every output is registered from these
    always_comb begin
        shreg_d    = shreg_q;
        bitcnt_d   = bitcnt_q;
        hit_cnt_d  = hit_cnt_q;
        hit_mask_d = hit_mask_q;
        det_x_d    = 1'b0;
        sample_c   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    shreg_d    = in_data;
                    bitcnt_d   = '0;
                    hit_cnt_d  = '0;
                    hit_mask_d = '0;
`ifndef SEQ_DET_CTRL_FRAME_CLR_EN
                    det_x_d    = in_data[WORD_W-1];
`endif
                end
            end
`ifdef SEQ_DET_CTRL_FRAME_CLR_EN
            // Detector held in reset this cycle; MSB goes out next
            S_CLR: begin
                det_x_d = shreg_q[WORD_W-1];
            end
`endif
            // shreg_q MSB is the bit on det_x now, so the next bit sits below it.
            // det_y in SHIFT bit 0 still reflects the previous frame: skip it.
            S_SHIFT: begin
                sample_c = (bitcnt_q != '0);
                shreg_d  = shreg_q << 1;
                bitcnt_d = bitcnt_q + BIT_W'(1);
                if (bitcnt_q != LAST_BIT) begin
                    det_x_d = shreg_q[WORD_W-2];
                end
            end
            // Collect the detector response to the last bit
            S_DRAIN: begin
                sample_c = 1'b1;
            end
            default: ;
        endcase

        if (sample_c) begin
            if ((det_y != '0) && (hit_cnt_q != CNT_MAX)) begin
                hit_cnt_d = hit_cnt_q + CNT_W'(1);
            end
            hit_mask_d = hit_mask_q | det_y;
        end
    end

    // Status flags follow the state being entered so they line up with it
    always_comb begin
        in_ready_d = (state_d == S_IDLE);
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_DONE);
`ifdef SEQ_DET_CTRL_FRAME_CLR_EN
        det_rst_d  = (state_d == S_CLR);
`else
        det_rst_d  = 1'b0;
`endif
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg_q    <= '0;
            bitcnt_q   <= '0;
            hit_cnt_q  <= '0;
            hit_mask_q <= '0;
            det_x_q    <= 1'b0;
            det_rst_q  <= 1'b1;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            shreg_q    <= shreg_d;
            bitcnt_q   <= bitcnt_d;
            hit_cnt_q  <= hit_cnt_d;
            hit_mask_q <= hit_mask_d;
            det_x_q    <= det_x_d;
            det_rst_q  <= det_rst_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready = in_ready_q;
    assign det_rst  = det_rst_q;
    assign det_x    = det_x_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign hit_cnt  = hit_cnt_q;
    assign hit_mask = hit_mask_q;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seq_det_ctrl
// Directed bench for seq_det_ctrl. Two instances share all inputs: u_dut with
// the default CNT_W=4 and u_sat with CNT_W=2 to exercise counter saturation.
// det_y is driven by the bench as a per-bit stub detector response.
// -----------------------------------------------------------------------------
module tb_seq_det_ctrl;

    localparam int unsigned WORD_W = 8;
    localparam int unsigned Y_W    = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid = 1'b0;
    logic [WORD_W-1:0] in_data  = '0;
    logic [Y_W-1:0]    det_y    = '0;

    logic              in_ready, det_rst, det_x, busy, done;
    logic [3:0]        hit_cnt;
    logic [Y_W-1:0]    hit_mask;

    logic              s_in_ready, s_det_rst, s_det_x, s_busy, s_done;
    logic [1:0]        s_hit_cnt;
    logic [Y_W-1:0]    s_hit_mask;

    seq_det_ctrl #(.WORD_W(WORD_W), .Y_W(Y_W), .CNT_W(4)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .det_rst(det_rst), .det_x(det_x), .det_y(det_y),
        .busy(busy), .done(done), .hit_cnt(hit_cnt), .hit_mask(hit_mask)
    );

    seq_det_ctrl #(.WORD_W(WORD_W), .Y_W(Y_W), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_data(in_data), .det_rst(s_det_rst), .det_x(s_det_x), .det_y(det_y),
        .busy(s_busy), .done(s_done), .hit_cnt(s_hit_cnt), .hit_mask(s_hit_mask)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int n_done = 0;

    // Count done pulses seen on the main instance
    always @(negedge clk) begin
        if (done === 1'b1) n_done++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    typedef struct {
        logic [7:0]      word;
        logic [8:0][3:0] ypat;   // [0]=SHIFT bit0 (unsampled) .. [7]=bit7, [8]=DRAIN
        logic [3:0]      cnt4;
        logic [1:0]      cnt2;
        logic [3:0]      mask;
    } vec_t;

    vec_t vecs[6];

    // Present a word in IDLE and let the accept edge pass
    task automatic send(input logic [7:0] w);
        @(negedge clk);
        chk("in_ready_idle", in_ready, 1'b1);
        in_valid = 1'b1;
        in_data  = w;
        @(posedge clk);
    endtask

    // Called right after the accept edge; ends at the negedge of the IDLE cycle after DONE
    task automatic run_frame(input logic [7:0] w, input logic [8:0][3:0] ypat,
                             input logic [3:0] e_cnt4, input logic [1:0] e_cnt2,
                             input logic [3:0] e_mask, input bit hold, input logic [7:0] nxt);
        @(negedge clk);
        in_valid = hold;
        in_data  = hold ? nxt : ~w;
`ifdef SEQ_DET_CTRL_FRAME_CLR_EN
        chk("clr_det_rst", det_rst, 1'b1);
        chk("clr_det_x", det_x, 1'b0);
        chk("clr_busy", busy, 1'b1);
        det_y = 4'hF;
        @(negedge clk);
`endif
        chk("shift_det_rst", det_rst, 1'b0);
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk);
            chk($sformatf("det_x_bit%0d", k), det_x, w[7-k]);
            chk("in_ready_busy", in_ready, 1'b0);
            chk("busy_shift", busy, 1'b1);
            chk("done_early", done, 1'b0);
            det_y = ypat[k];
        end
        @(negedge clk);
        chk("drain_det_x", det_x, 1'b0);
        chk("drain_done", done, 1'b0);
        det_y = ypat[8];
        @(negedge clk);
        chk("done_pulse", done, 1'b1);
        chk("done_pulse_sat", s_done, 1'b1);
        chk("hit_cnt", hit_cnt, e_cnt4);
        chk("hit_cnt_sat", s_hit_cnt, e_cnt2);
        chk("hit_mask", hit_mask, e_mask);
        chk("hit_mask_sat", s_hit_mask, e_mask);
        det_y = 4'hF;
        @(negedge clk);
        chk("done_one_cycle", done, 1'b0);
        chk("in_ready_after", in_ready, 1'b1);
        chk("busy_after", busy, 1'b0);
        chk("hit_cnt_held", hit_cnt, e_cnt4);
        chk("hit_mask_held", hit_mask, e_mask);
        det_y = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int done_before;
        logic [8:0][3:0] zy;
        zy = '0;

        vecs[0].word = 8'hA5; vecs[0].ypat = '0; vecs[0].ypat[0] = 4'hF;
        vecs[0].cnt4 = 4'd0;  vecs[0].cnt2 = 2'd0; vecs[0].mask = 4'b0000;

        vecs[1].word = 8'h3C; vecs[1].ypat = '0;
        vecs[1].ypat[1] = 4'b0010; vecs[1].ypat[3] = 4'b0010;
        vecs[1].ypat[5] = 4'b0010; vecs[1].ypat[8] = 4'b1000;
        vecs[1].cnt4 = 4'd4;  vecs[1].cnt2 = 2'd3; vecs[1].mask = 4'b1010;

        vecs[2].word = 8'h96;
        for (int j = 0; j < 9; j++) vecs[2].ypat[j] = (j == 0) ? 4'b0000 : 4'b0001;
        vecs[2].cnt4 = 4'd8;  vecs[2].cnt2 = 2'd3; vecs[2].mask = 4'b0001;

        vecs[3].word = 8'h5A; vecs[3].ypat = '0;
        vecs[3].ypat[0] = 4'b1000; vecs[3].ypat[1] = 4'b0100;
        vecs[3].ypat[3] = 4'b0001; vecs[3].ypat[5] = 4'b0100; vecs[3].ypat[8] = 4'b0001;
        vecs[3].cnt4 = 4'd4;  vecs[3].cnt2 = 2'd3; vecs[3].mask = 4'b0101;

        vecs[4].word = 8'h00; vecs[4].ypat = '0; vecs[4].ypat[8] = 4'b0010;
        vecs[4].cnt4 = 4'd1;  vecs[4].cnt2 = 2'd1; vecs[4].mask = 4'b0010;

        vecs[5].word = 8'h81; vecs[5].ypat = '0;
        vecs[5].cnt4 = 4'd0;  vecs[5].cnt2 = 2'd0; vecs[5].mask = 4'b0000;

        // Reset state
        rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("rst_det_rst", det_rst, 1'b1);
        chk("rst_det_x", det_x, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_hit_cnt", hit_cnt, 4'd0);
        chk("rst_hit_mask", hit_mask, 4'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("det_rst_released", det_rst, 1'b0);

        // Table-driven frames
        for (int i = 0; i < 6; i++) begin
            send(vecs[i].word);
            run_frame(vecs[i].word, vecs[i].ypat, vecs[i].cnt4, vecs[i].cnt2,
                      vecs[i].mask, 1'b0, 8'h00);
        end

        // Results held across idle cycles with det_y active
        det_y = 4'hF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_hold_cnt", hit_cnt, 4'd0);
            chk("idle_hold_mask", hit_mask, 4'd0);
            chk("idle_det_x", det_x, 1'b0);
        end
        det_y = '0;

        // in_valid held high across two words: FF then 00
        done_before = n_done;
        send(8'hFF);
        run_frame(8'hFF, zy, 4'd0, 2'd0, 4'd0, 1'b1, 8'h00);
        @(posedge clk);
        run_frame(8'h00, zy, 4'd0, 2'd0, 4'd0, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("no_extra_frame", busy, 1'b0);
        end
        chk("b2b_done_count", n_done - done_before, 2);

        // Reset during SHIFT bit 4 abandons the frame
        done_before = n_done;
        send(8'hC3);
        @(negedge clk);
        in_valid = 1'b0;
`ifdef SEQ_DET_CTRL_FRAME_CLR_EN
        @(negedge clk);
`endif
        repeat (4) @(negedge clk);
        chk("pre_rst_det_x", det_x, 1'b0);   // bit 4 of C3
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_det_rst", det_rst, 1'b1);
        chk("mid_rst_det_x", det_x, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_in_ready", in_ready, 1'b1);
        chk("mid_rst_done", done, 1'b0);
        chk("mid_rst_hit_cnt", hit_cnt, 4'd0);
        @(negedge clk);
        rst = 1'b1;
        chk("rel_det_rst_high", det_rst, 1'b1);
        @(negedge clk);
        chk("rel_det_rst_low", det_rst, 1'b0);
        repeat (10) @(negedge clk);
        chk("rst_no_done", n_done - done_before, 0);
        send(vecs[1].word);
        run_frame(vecs[1].word, vecs[1].ypat, vecs[1].cnt4, vecs[1].cnt2,
                  vecs[1].mask, 1'b0, 8'h00);
        chk("total_done_count", n_done, 9);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
